// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Stall / flush / bypass-select generator for the 5-stage F->D->E->M->W
//   pipeline. Decodes the instruction in D and keeps its own E/M/W shadow of
//   destination register (A3) and Tnew, from which it derives the F/D stall,
//   the D/E bubble and the bypass selects for the D, E and M stages.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset (0 = reset asserted)
//   IR_D       in   [31:0] instruction currently in D
//   Stall_F    out  1 = hold PC
//   Stall_D    out  1 = hold F/D register
//   DE_clr     out  1 = load bubble into D/E
//   FwdRS_D    out  [1:0] D rs bypass: 00 GRF, 01 E (jal PC+8), 10 M, 11 W
//   FwdRT_D    out  [1:0] D rt bypass: same encoding as FwdRS_D
//   FwdA_E     out  [1:0] ALU A bypass: 00 register, 10 M, 11 W
//   FwdB_E     out  [1:0] ALU B / store data bypass: 00 register, 10 M, 11 W
//   FwdWD_M    out  1 = DM write data taken from W result
//   stall_cnt  out  [CNT_W-1:0] saturating stall-cycle count
//
// Build option
//   HAZARD_STAT_EN : when defined, adds the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_D,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        DE_clr,
    output logic [1:0]  FwdRS_D,
    output logic [1:0]  FwdRT_D,
    output logic [1:0]  FwdA_E,
    output logic [1:0]  FwdB_E,
    output logic        FwdWD_M
`ifdef HAZARD_STAT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    // Instruction fields; shamt is never needed by any decoded instruction.
    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rs_s;
    logic [4:0] rt_s;
    logic [4:0] rd_s;
    logic       unused_shamt_s;

    assign op_s           = IR_D[31:26];
    assign rs_s           = IR_D[25:21];
    assign rt_s           = IR_D[20:16];
    assign rd_s           = IR_D[15:11];
    assign funct_s        = IR_D[5:0];
    assign unused_shamt_s = ^IR_D[10:6];

    // D-stage decode results
    logic       rs_use_s;
    logic       rt_use_s;
    logic [1:0] tuse_rs_s;
    logic [1:0] tuse_rt_s;
    logic [1:0] tnew_s;
    logic [4:0] a3_s;

    // Shadow pipeline registers
    logic [4:0] a3_e_q,   a3_e_d;
    logic [1:0] tnew_e_q, tnew_e_d;
    logic [4:0] rs_e_q,   rs_e_d;
    logic [4:0] rt_e_q,   rt_e_d;
    logic [4:0] a3_m_q,   a3_m_d;
    logic [1:0] tnew_m_q, tnew_m_d;
    logic [4:0] rt_m_q,   rt_m_d;
    logic [4:0] a3_w_q,   a3_w_d;

    logic stall_s;

    // True when a producer in E or M cannot deliver src in time for its use.
    function automatic logic src_hazard(input logic used, input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                        input logic [4:0] a3_m, input logic [1:0] tnew_m);
        logic hit;
        if (used && (src != 5'd0)) begin
            hit = ((a3_e == src) && (tnew_e > tuse)) ||
                  ((a3_m == src) && (tnew_m > tuse));
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    // D-stage bypass: the nearest stage whose result is already available wins.
    function automatic logic [1:0] fwd_d(input logic used, input logic [4:0] src,
                                         input logic [4:0] a3_e, input logic [1:0] tnew_e,
                                         input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                         input logic [4:0] a3_w);
        logic [1:0] sel;
        if (!used || (src == 5'd0)) begin
            sel = 2'b00;
        end else if ((a3_e == src) && (tnew_e == 2'd0)) begin
            sel = 2'b01;
        end else if ((a3_m == src) && (tnew_m == 2'd0)) begin
            sel = 2'b10;
        end else if (a3_w == src) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // E-stage bypass from M or W.
    function automatic logic [1:0] fwd_e(input logic [4:0] src,
                                         input logic [4:0] a3_m, input logic [1:0] tnew_m,
                                         input logic [4:0] a3_w);
        logic [1:0] sel;
        if (src == 5'd0) begin
            sel = 2'b00;
        end else if ((a3_m == src) && (tnew_m == 2'd0)) begin
            sel = 2'b10;
        end else if (a3_w == src) begin
            sel = 2'b11;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Decode source usage, Tuse, Tnew and destination of the D instruction.
    always_comb begin
        rs_use_s  = 1'b0;
        rt_use_s  = 1'b0;
        tuse_rs_s = 2'd0;
        tuse_rt_s = 2'd0;
        tnew_s    = 2'd0;
        a3_s      = 5'd0;
        case (op_s)
            OP_SPECIAL: begin
                case (funct_s)
                    FN_ADDU, FN_SUBU: begin
                        rs_use_s  = 1'b1;
                        rt_use_s  = 1'b1;
                        tuse_rs_s = 2'd1;
                        tuse_rt_s = 2'd1;
                        tnew_s    = 2'd1;
                        a3_s      = rd_s;
                    end
                    FN_JR: begin
                        rs_use_s  = 1'b1;
                        tuse_rs_s = 2'd0;
                    end
                    default: begin
                        rs_use_s = 1'b0;
                    end
                endcase
            end
            OP_ORI: begin
                rs_use_s  = 1'b1;
                tuse_rs_s = 2'd1;
                tnew_s    = 2'd1;
                a3_s      = rt_s;
            end
            OP_LUI: begin
                tnew_s = 2'd1;
                a3_s   = rt_s;
            end
            OP_LW: begin
                rs_use_s  = 1'b1;
                tuse_rs_s = 2'd1;
                tnew_s    = 2'd2;
                a3_s      = rt_s;
            end
            OP_SW: begin
                rs_use_s  = 1'b1;
                rt_use_s  = 1'b1;
                tuse_rs_s = 2'd1;
                tuse_rt_s = 2'd2;
            end
            OP_BEQ: begin
                rs_use_s  = 1'b1;
                rt_use_s  = 1'b1;
                tuse_rs_s = 2'd0;
                tuse_rt_s = 2'd0;
            end
            OP_JAL: begin
                tnew_s = 2'd0;
                a3_s   = 5'd31;
            end
            OP_J: begin
                // Jump touches no register, same as a nop here.
                a3_s = 5'd0;
            end
            default: begin
                a3_s = 5'd0;
            end
        endcase
    end

    // Stall when either source would be needed before its producer has it.
    always_comb begin
        stall_s = src_hazard(rs_use_s, rs_s, tuse_rs_s, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q) ||
                  src_hazard(rt_use_s, rt_s, tuse_rt_s, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q);
    end

    // Next state of the shadow pipeline; a stall injects an all-zero bubble into E.
    always_comb begin
        if (stall_s) begin
            a3_e_d   = 5'd0;
            tnew_e_d = 2'd0;
            rs_e_d   = 5'd0;
            rt_e_d   = 5'd0;
        end else begin
            a3_e_d   = a3_s;
            tnew_e_d = tnew_s;
            rs_e_d   = rs_use_s ? rs_s : 5'd0;
            rt_e_d   = rt_use_s ? rt_s : 5'd0;
        end
        a3_m_d = a3_e_q;
        if (tnew_e_q != 2'd0) begin
            tnew_m_d = tnew_e_q - 2'd1;
        end else begin
            tnew_m_d = 2'd0;
        end
        rt_m_d = rt_e_q;
        a3_w_d = a3_m_q;
    end

    // Shadow pipeline registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a3_e_q   <= 5'd0;
            tnew_e_q <= 2'd0;
            rs_e_q   <= 5'd0;
            rt_e_q   <= 5'd0;
            a3_m_q   <= 5'd0;
            tnew_m_q <= 2'd0;
            rt_m_q   <= 5'd0;
            a3_w_q   <= 5'd0;
        end else begin
            a3_e_q   <= a3_e_d;
            tnew_e_q <= tnew_e_d;
            rs_e_q   <= rs_e_d;
            rt_e_q   <= rt_e_d;
            a3_m_q   <= a3_m_d;
            tnew_m_q <= tnew_m_d;
            rt_m_q   <= rt_m_d;
            a3_w_q   <= a3_w_d;
        end
    end

    assign Stall_F = stall_s;
    assign Stall_D = stall_s;
    assign DE_clr  = stall_s;
    assign FwdRS_D = fwd_d(rs_use_s, rs_s, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign FwdRT_D = fwd_d(rt_use_s, rt_s, a3_e_q, tnew_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign FwdA_E  = fwd_e(rs_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign FwdB_E  = fwd_e(rt_e_q, a3_m_q, tnew_m_q, a3_w_q);
    assign FwdWD_M = (rt_m_q != 5'd0) && (rt_m_q == a3_w_q);

`ifdef HAZARD_STAT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // Saturating count of stalled cycles.
    always_comb begin
        if (stall_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    // Counter width only matters when the statistics option is built in.
    if (CNT_W > 0) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit. Observed outputs are packed as
//   {Stall_F,Stall_D,DE_clr, FwdRS_D, FwdRT_D, FwdA_E, FwdB_E, FwdWD_M}.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int CNT_W = 16;

    localparam logic [31:0] I_NOP      = 32'h0000_0000;
    localparam logic [31:0] I_LW1      = 32'h8C01_0000; // lw   $1,0($0)
    localparam logic [31:0] I_ADDU_312 = 32'h0022_1821; // addu $3,$1,$2
    localparam logic [31:0] I_ADDU_412 = 32'h0022_2021; // addu $4,$1,$2
    localparam logic [31:0] I_ADDU_311 = 32'h0021_1821; // addu $3,$1,$1
    localparam logic [31:0] I_ORI1     = 32'h3401_0005; // ori  $1,$0,5
    localparam logic [31:0] I_ORI0     = 32'h3400_0005; // ori  $0,$0,5
    localparam logic [31:0] I_BEQ12    = 32'h1022_0000; // beq  $1,$2
    localparam logic [31:0] I_BEQ00    = 32'h1000_0000; // beq  $0,$0
    localparam logic [31:0] I_SW1      = 32'hAC01_0000; // sw   $1,0($0)
    localparam logic [31:0] I_JAL      = 32'h0C00_0000;
    localparam logic [31:0] I_JR31     = 32'h03E0_0008;

    logic        clk;
    logic        reset;
    logic [31:0] IR_D;
    logic        Stall_F;
    logic        Stall_D;
    logic        DE_clr;
    logic [1:0]  FwdRS_D;
    logic [1:0]  FwdRT_D;
    logic [1:0]  FwdA_E;
    logic [1:0]  FwdB_E;
    logic        FwdWD_M;
`ifdef HAZARD_STAT_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    logic [11:0] obs;
    int          n_checks;
    int          n_fail;

    assign obs = {Stall_F, Stall_D, DE_clr, FwdRS_D, FwdRT_D, FwdA_E, FwdB_E, FwdWD_M};

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .IR_D    (IR_D),
        .Stall_F (Stall_F),
        .Stall_D (Stall_D),
        .DE_clr  (DE_clr),
        .FwdRS_D (FwdRS_D),
        .FwdRT_D (FwdRT_D),
        .FwdA_E  (FwdA_E),
        .FwdB_E  (FwdB_E),
        .FwdWD_M (FwdWD_M)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [31:0] ir);
        IR_D = ir;
        #1;
    endtask

    task automatic flush;
        IR_D = I_NOP;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        reset = 1'b0;
        IR_D  = I_ADDU_312;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
`ifdef HAZARD_STAT_EN
        n_checks++;
        if (stall_cnt !== {CNT_W{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
`endif
        reset = 1'b1;
        flush();
    endtask

    task automatic test_lw_use;
        flush();
        set_ir(I_LW1);
        tick();
        set_ir(I_ADDU_312);
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_use_stall: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_use_release: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        set_ir(I_NOP);
        n_checks++;
        if (obs !== 12'b000_00_00_11_00_0) begin
            n_fail++;
            $display("FAIL lw_use_fwdA_W: got %b expected %b", obs, 12'b000_00_00_11_00_0);
        end
    endtask

    task automatic test_fwd_e_m;
        flush();
        set_ir(I_ORI1);
        tick();
        set_ir(I_ADDU_412);
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL alu_alu_nostall: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        set_ir(I_NOP);
        n_checks++;
        if (obs !== 12'b000_00_00_10_00_0) begin
            n_fail++;
            $display("FAIL alu_alu_fwdA_M: got %b expected %b", obs, 12'b000_00_00_10_00_0);
        end
    endtask

    task automatic test_ori_beq;
        flush();
        set_ir(I_ORI1);
        tick();
        set_ir(I_BEQ12);
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL ori_beq_stall: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_10_00_00_00_0) begin
            n_fail++;
            $display("FAIL ori_beq_fwd_M: got %b expected %b", obs, 12'b000_10_00_00_00_0);
        end
    endtask

    task automatic test_lw_beq;
        flush();
        set_ir(I_LW1);
        tick();
        set_ir(I_BEQ12);
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_beq_stall1: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_beq_stall2: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_11_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_beq_fwd_W: got %b expected %b", obs, 12'b000_11_00_00_00_0);
        end
    endtask

    task automatic test_lw_sw;
        flush();
        set_ir(I_LW1);
        tick();
        set_ir(I_SW1);
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_sw_nostall: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        set_ir(I_NOP);
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL lw_sw_in_E: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_1) begin
            n_fail++;
            $display("FAIL lw_sw_fwdWD: got %b expected %b", obs, 12'b000_00_00_00_00_1);
        end
    endtask

    task automatic test_jal_jr;
        flush();
        set_ir(I_JAL);
        tick();
        set_ir(I_JR31);
        n_checks++;
        if (obs !== 12'b000_01_00_00_00_0) begin
            n_fail++;
            $display("FAIL jal_jr_fwd_E: got %b expected %b", obs, 12'b000_01_00_00_00_0);
        end
        tick();
        set_ir(I_NOP);
        n_checks++;
        if (obs !== 12'b000_00_00_10_00_0) begin
            n_fail++;
            $display("FAIL jal_jr_fwdA_M: got %b expected %b", obs, 12'b000_00_00_10_00_0);
        end
    endtask

    task automatic test_reg_zero;
        flush();
        set_ir(I_ORI0);
        tick();
        set_ir(I_BEQ00);
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL zero_no_stall: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL zero_no_fwd: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
    endtask

    task automatic test_rs_eq_rt;
        flush();
        set_ir(I_LW1);
        tick();
        set_ir(I_ADDU_311);
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL rs_eq_rt_stall: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
        tick();
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL rs_eq_rt_release: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
        tick();
        set_ir(I_NOP);
        n_checks++;
        if (obs !== 12'b000_00_00_11_11_0) begin
            n_fail++;
            $display("FAIL rs_eq_rt_fwd_W: got %b expected %b", obs, 12'b000_00_00_11_11_0);
        end
    endtask

    task automatic test_reset_mid_stall;
        flush();
        set_ir(I_LW1);
        tick();
        set_ir(I_BEQ12);
        tick();
        n_checks++;
        if (obs !== 12'b111_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL mid_stall_pre: got %b expected %b", obs, 12'b111_00_00_00_00_0);
        end
`ifdef HAZARD_STAT_EN
        n_checks++;
        if (stall_cnt === {CNT_W{1'b0}}) begin
            n_fail++;
            $display("FAIL mid_stall_cnt_pre: got %0d expected nonzero", stall_cnt);
        end
`endif
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL mid_stall_reset: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
`ifdef HAZARD_STAT_EN
        n_checks++;
        if (stall_cnt !== {CNT_W{1'b0}}) begin
            n_fail++;
            $display("FAIL mid_stall_cnt_clr: got %0d expected 0", stall_cnt);
        end
`endif
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs !== 12'b000_00_00_00_00_0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %b expected %b", obs, 12'b000_00_00_00_00_0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        IR_D     = I_NOP;
        test_reset();
        test_lw_use();
        test_fwd_e_m();
        test_ori_beq();
        test_lw_beq();
        test_lw_sw();
        test_jal_jr();
        test_reg_zero();
        test_rs_eq_rt();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
